// File: rtl/bluemax_platform_debug_ocimem_pkg.sv
// Shared types and jdo field positions for the debug-RAM controller.
package bluemax_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRD  = 2'd1,
    CRD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_A    = 2'd1,
    ACT_NA   = 2'd2,
    ACT_B    = 2'd3
  } act_t;

  localparam int ADDR_LSB   = 17;
  localparam int ADDR_W_JDO = 10;
  localparam int WDATA_LSB  = 3;
  localparam int CLR_BIT    = 34;
  localparam int RDLOAD_BIT = 35;

  // Simultaneous pulses resolve b > a > no_action_a; the losers are dropped.
  function automatic act_t decode_act(input logic b, input logic a, input logic na);
    if (b)  return ACT_B;
    if (a)  return ACT_A;
    if (na) return ACT_NA;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/bluemax_platform_debug_ocimem_if.sv
// Avalon-MM slave bundle through which the Nios II monitor code reaches the debug RAM.
interface bluemax_platform_debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/bluemax_platform_debug_ocimem_ram.sv
// Single-port synchronous RAM, 32-bit words with byte enables, read-first, 1-cycle read latency.
module bluemax_platform_debug_ocimem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bluemax_platform_debug_ocimem.sv
// Debug-RAM controller serving JTAG debug-slave actions, with an optional CPU port
// (BLUEMAX_DBGRAM_CPU_PORT_EN); debug traffic always wins arbitration.
module bluemax_platform_debug_ocimem
  import bluemax_debug_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  bluemax_platform_debug_ocimem_if.slave avs
);

  localparam logic [10:0] DEPTH_L = 11'(DEPTH);

  function automatic logic in_range(input logic [9:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  state_t            state_q, state_d;
  logic [9:0]        dbg_addr, dbg_addr_d;
  logic [31:0]       mon_d;
  logic              ready_d, error_d;
  logic              rd_oor, rd_oor_d;
  logic              pend_vld, pend_vld_d;
  act_t              pend_act, pend_act_d;
  logic [37:0]       pend_jdo, pend_jdo_d;
  act_t              pulse_act, srv_act;
  logic [37:0]       srv_jdo;
  logic [9:0]        srv_a_addr;
  logic [31:0]       srv_wdata;
  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  // In IDLE a pending action is served ahead of a fresh pulse.
  assign pulse_act  = decode_act(take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a);
  assign srv_act    = pend_vld ? pend_act : pulse_act;
  assign srv_jdo    = pend_vld ? pend_jdo : jdo;
  assign srv_a_addr = srv_jdo[ADDR_LSB +: ADDR_W_JDO];
  assign srv_wdata  = srv_jdo[WDATA_LSB +: 32];

  wire unused_jdo = ^{srv_jdo[37:36], srv_jdo[2:0]};

  always_comb begin
    state_d    = state_q;
    dbg_addr_d = dbg_addr;
    mon_d      = MonDReg;
    ready_d    = monitor_ready;
    error_d    = monitor_error;
    rd_oor_d   = rd_oor;
    pend_vld_d = pend_vld;
    pend_act_d = pend_act;
    pend_jdo_d = pend_jdo;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_be     = 4'h0;
    ram_addr   = '0;
    ram_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (pend_vld) begin
          pend_vld_d = (pulse_act != ACT_NONE);
          pend_act_d = pulse_act;
          pend_jdo_d = jdo;
        end
        unique case (srv_act)
          ACT_B: begin
            if (in_range(dbg_addr)) begin
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_be    = 4'hF;
              ram_addr  = dbg_addr[ADDR_W-1:0];
              ram_wdata = srv_wdata;
              error_d   = 1'b0;
            end else begin
              error_d   = 1'b1;
            end
            ready_d    = 1'b1;
            dbg_addr_d = dbg_addr + 10'd1;
          end
          ACT_A: begin
            dbg_addr_d = srv_a_addr;
            if (srv_jdo[CLR_BIT]) begin
              ready_d = 1'b0;
              error_d = 1'b0;
            end
            if (srv_jdo[RDLOAD_BIT]) begin
              ready_d  = 1'b0;
              rd_oor_d = !in_range(srv_a_addr);
              ram_en   = in_range(srv_a_addr);
              ram_addr = srv_a_addr[ADDR_W-1:0];
              state_d  = DRD;
            end
          end
          ACT_NA: begin
            ready_d  = 1'b0;
            rd_oor_d = !in_range(dbg_addr);
            ram_en   = in_range(dbg_addr);
            ram_addr = dbg_addr[ADDR_W-1:0];
            state_d  = DRD;
          end
          default: begin
`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
            if (avs.avs_read) begin
              ram_en   = 1'b1;
              ram_addr = avs.avs_address;
              state_d  = CRD;
            end else if (avs.avs_write) begin
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_be    = avs.avs_byteenable;
              ram_addr  = avs.avs_address;
              ram_wdata = avs.avs_writedata;
            end
`endif
          end
        endcase
      end
      DRD: begin
        if (rd_oor) begin
          error_d = 1'b1;
        end else begin
          mon_d   = ram_rdata;
          error_d = 1'b0;
        end
        ready_d    = 1'b1;
        dbg_addr_d = dbg_addr + 10'd1;
        state_d    = IDLE;
        if (pulse_act != ACT_NONE && !pend_vld) begin
          pend_vld_d = 1'b1;
          pend_act_d = pulse_act;
          pend_jdo_d = jdo;
        end
      end
`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
      CRD: begin
        state_d = IDLE;
        if (pulse_act != ACT_NONE && !pend_vld) begin
          pend_vld_d = 1'b1;
          pend_act_d = pulse_act;
          pend_jdo_d = jdo;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dbg_addr      <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_oor        <= 1'b0;
      pend_vld      <= 1'b0;
      pend_act      <= ACT_NONE;
      pend_jdo      <= '0;
    end else begin
      state_q       <= state_d;
      dbg_addr      <= dbg_addr_d;
      MonDReg       <= mon_d;
      monitor_ready <= ready_d;
      monitor_error <= error_d;
      rd_oor        <= rd_oor_d;
      pend_vld      <= pend_vld_d;
      pend_act      <= pend_act_d;
      pend_jdo      <= pend_jdo_d;
    end
  end

`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
  // CPU completes only in CRD, or on an uncontested write in IDLE.
  assign avs.avs_waitrequest = !reset_n ||
      !((state_q == CRD) ||
        (state_q == IDLE && avs.avs_write && !avs.avs_read && srv_act == ACT_NONE));
  assign avs.avs_readdata = (state_q == CRD) ? ram_rdata : 32'h0;
`else
  assign avs.avs_waitrequest = 1'b0;
  assign avs.avs_readdata    = 32'h0;
  wire unused_cpu = ^{avs.avs_address, avs.avs_read, avs.avs_write,
                      avs.avs_writedata, avs.avs_byteenable};
`endif

  bluemax_platform_debug_ocimem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bluemax_platform_debug_ocimem.sv
// Directed bench for the debug-RAM controller; CPU-port steps follow BLUEMAX_DBGRAM_CPU_PORT_EN.
module tb_bluemax_platform_debug_ocimem;
  import bluemax_debug_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [31:0] mon;
  logic        rdy, err;
  int          checks = 0;
  int          errors = 0;

  bluemax_platform_debug_ocimem_if #(.ADDR_W(ADDR_W)) avs ();

  bluemax_platform_debug_ocimem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .MonDReg                 (mon),
    .monitor_ready           (rdy),
    .monitor_error           (err),
    .avs                     (avs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] j_a(input logic [9:0] a, input logic clr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[26:17] = a;
    j[34] = clr;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] j_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic pulse_a(input logic [9:0] a, input logic clr, input logic rd);
    jdo = j_a(a, clr, rd);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    jdo = '1;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = j_b(d);
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    jdo = '1;
  endtask

  task automatic pulse_na();
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
  endtask

  initial begin
    logic [31:0] be_exp;
    reset_n = 1'b0;
    jdo = '0;
    ta_a = 1'b0;
    tna_a = 1'b0;
    ta_b = 1'b0;
    avs.avs_address = '0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = '0;
    avs.avs_byteenable = '0;
    #12;
`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
    chk("rst_waitreq", 32'(avs.avs_waitrequest), 32'd1);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_mon", mon, 32'h0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_rdata", avs.avs_readdata, 32'h0);
    chk("rst_addr", 32'(dut.dbg_addr), 32'd0);

    // Address load, write, read-back with rdload
    pulse_a(10'h004, 1'b0, 1'b0);
    chk("a_load_addr", 32'(dut.dbg_addr), 32'h004);
    pulse_b(32'hA5A5_0001);
    chk("b_ready", 32'(rdy), 32'd1);
    chk("b_error", 32'(err), 32'd0);
    chk("b_addr_inc", 32'(dut.dbg_addr), 32'h005);
    pulse_a(10'h004, 1'b0, 1'b1);
    chk("rd_ready_clr", 32'(rdy), 32'd0);
    tick();
    chk("rd_mon", mon, 32'hA5A5_0001);
    chk("rd_ready", 32'(rdy), 32'd1);
    chk("rd_addr", 32'(dut.dbg_addr), 32'h005);

    // Out-of-range read then wrap to word 0
    pulse_a(10'h000, 1'b0, 1'b0);
    pulse_b(32'h1234_5678);
    pulse_b(32'h9ABC_DEF0);
    pulse_a(10'h3FF, 1'b1, 1'b0);
    chk("clr_ready", 32'(rdy), 32'd0);
    chk("clr_addr", 32'(dut.dbg_addr), 32'h3FF);
    tna_a = 1'b1;
    tick();
    tick();
    chk("oor_error", 32'(err), 32'd1);
    chk("oor_ready", 32'(rdy), 32'd1);
    chk("oor_mon_kept", mon, 32'hA5A5_0001);
    chk("wrap_addr", 32'(dut.dbg_addr), 32'h000);
    tick();
    chk("pend_rd_ready_clr", 32'(rdy), 32'd0);
    tna_a = 1'b0;
    tick();
    chk("wrap_mon", mon, 32'h1234_5678);
    chk("wrap_error_clr", 32'(err), 32'd0);
    chk("wrap_addr1", 32'(dut.dbg_addr), 32'h001);
    tick();
    tick();
    chk("third_mon", mon, 32'h9ABC_DEF0);
    chk("third_addr", 32'(dut.dbg_addr), 32'h002);
    chk("third_pend", 32'(dut.pend_vld), 32'd0);

`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
    // CPU read colliding with a debug write to the same word
    avs.avs_address = 8'd2;
    avs.avs_read = 1'b1;
    jdo = j_b(32'hCAFE_0002);
    ta_b = 1'b1;
    #1;
    chk("coll_wait", 32'(avs.avs_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    ta_b = 1'b0;
    jdo = '1;
    chk("coll_wr_ready", 32'(rdy), 32'd1);
    chk("coll_wr_addr", 32'(dut.dbg_addr), 32'h003);
    chk("coll_wait2", 32'(avs.avs_waitrequest), 32'd1);
    tick();
    chk("crd_wait", 32'(avs.avs_waitrequest), 32'd0);
    chk("crd_rdata", avs.avs_readdata, 32'hCAFE_0002);
    avs.avs_read = 1'b0;
    tick();

    // Debug write arriving during CRD is held as pending
    avs.avs_address = 8'd0;
    avs.avs_read = 1'b1;
    tick();
    jdo = j_b(32'h0BAD_F00D);
    ta_b = 1'b1;
    #1;
    chk("crd0_rdata", avs.avs_readdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    ta_b = 1'b0;
    jdo = '1;
    avs.avs_read = 1'b0;
    chk("pend_set", 32'(dut.pend_vld), 32'd1);
    chk("pend_addr_hold", 32'(dut.dbg_addr), 32'h003);
    tick();
    chk("pend_served", 32'(dut.pend_vld), 32'd0);
    chk("pend_wr_addr", 32'(dut.dbg_addr), 32'h004);
    chk("pend_wr_ready", 32'(rdy), 32'd1);
    pulse_a(10'h003, 1'b0, 1'b1);
    tick();
    chk("pend_wr_data", mon, 32'h0BAD_F00D);
    be_exp = 32'hFFFF_ABFF;
`else
    be_exp = 32'hFFFF_FFFF;
`endif

    // CPU byte-enable write over an all-ones word
    pulse_a(10'h005, 1'b0, 1'b0);
    pulse_b(32'hFFFF_FFFF);
    avs.avs_address = 8'd5;
    avs.avs_byteenable = 4'b0010;
    avs.avs_writedata = 32'h0000_AB00;
    avs.avs_write = 1'b1;
    #1;
    chk("cpu_wr_wait", 32'(avs.avs_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    avs.avs_write = 1'b0;
    chk("cpu_wr_rdata", avs.avs_readdata, 32'h0);
    pulse_a(10'h005, 1'b0, 1'b1);
    tick();
    chk("be_readback", mon, be_exp);

    // Reset during DRD with a pending action
    pulse_a(10'h000, 1'b1, 1'b0);
    tna_a = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_state", 32'(dut.state_q), 32'(DRD));
    chk("pre_rst_pend", 32'(dut.pend_vld), 32'd1);
    #2;
    reset_n = 1'b0;
    tna_a = 1'b0;
    #1;
    chk("mid_rst_mon", mon, 32'h0);
    chk("mid_rst_ready", 32'(rdy), 32'd0);
    chk("mid_rst_error", 32'(err), 32'd0);
    chk("mid_rst_addr", 32'(dut.dbg_addr), 32'd0);
    chk("mid_rst_pend", 32'(dut.pend_vld), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mid_rst_rdata", avs.avs_readdata, 32'h0);
`ifdef BLUEMAX_DBGRAM_CPU_PORT_EN
    chk("mid_rst_wait", 32'(avs.avs_waitrequest), 32'd1);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    pulse_na();
    chk("post_rst_ready_clr", 32'(rdy), 32'd0);
    tick();
    chk("post_rst_mon", mon, 32'h1234_5678);
    chk("post_rst_ready", 32'(rdy), 32'd1);
    chk("post_rst_addr", 32'(dut.dbg_addr), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
